// File: rtl/layer_fx_ctrl.sv
// layer_fx_ctrl: frame-synchronous sequencer for the compositor layer and
// overlay enables. Event pulses are latched during a frame and take effect
// only on frame_tick, so no layer changes while a frame is being scanned out.
// Also runs the attack overlay show/cooldown FSM and the hit-blink sequencer.
module layer_fx_ctrl #(
    parameter int ATTACK_FRAMES   = 8,
    parameter int COOLDOWN_FRAMES = 16,
    parameter int HIT_FRAMES      = 60,
    parameter int BLINK_PERIOD    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic sp_toggle,
    input  logic attack_req,
    input  logic player_hit,
    output logic display_sp,
    output logic attack_en,
    output logic attack_busy,
    output logic player_visible,
    output logic invuln
);

    localparam int ATK_MAX = (ATTACK_FRAMES > COOLDOWN_FRAMES) ? ATTACK_FRAMES : COOLDOWN_FRAMES;
    localparam int ATK_W   = (ATK_MAX > 1) ? $clog2(ATK_MAX) : 1;
    localparam int HIT_W   = $clog2(HIT_FRAMES + 1);
    localparam int BLINK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

    localparam logic [ATK_W-1:0]   ATK_SHOW_LOAD = ATK_W'(ATTACK_FRAMES - 1);
    localparam logic [ATK_W-1:0]   ATK_COOL_LOAD = ATK_W'(COOLDOWN_FRAMES - 1);
    localparam logic [HIT_W-1:0]   HIT_LOAD      = HIT_W'(HIT_FRAMES);
    localparam logic [BLINK_W-1:0] BLINK_LAST    = BLINK_W'(BLINK_PERIOD - 1);

    typedef enum logic [1:0] {
        ATK_IDLE,
        ATK_SHOW,
        ATK_COOL
    } atk_state_e;

    atk_state_e         atkState_q,  atkState_d;
    logic [ATK_W-1:0]   atkCnt_q,    atkCnt_d;
    logic               attackEn_q,  attackEn_d;
    logic [HIT_W-1:0]   hitCnt_q,    hitCnt_d;
    logic [BLINK_W-1:0] blinkCnt_q,  blinkCnt_d;
    logic               visible_q,   visible_d;
    logic               invuln_q,    invuln_d;
    logic               displaySp_q, displaySp_d;
    logic               spPend_q,    spPend_d;
    logic               atkPend_q,   atkPend_d;
    logic               hitPend_q,   hitPend_d;

    // A pulse arriving on the tick cycle itself still counts for that frame
    logic spReq;
    logic atkReq;
    logic hitReq;

    assign spReq  = spPend_q  | sp_toggle;
    assign atkReq = atkPend_q | attack_req;
    assign hitReq = hitPend_q | player_hit;

    // Next-state logic: pending latches between ticks, sequencers on ticks
    always_comb begin
        atkState_d  = atkState_q;
        atkCnt_d    = atkCnt_q;
        attackEn_d  = attackEn_q;
        hitCnt_d    = hitCnt_q;
        blinkCnt_d  = blinkCnt_q;
        visible_d   = visible_q;
        invuln_d    = invuln_q;
        displaySp_d = displaySp_q;
        spPend_d    = spPend_q;
        atkPend_d   = atkPend_q;
        hitPend_d   = hitPend_q;

        if (frame_tick) begin
            spPend_d  = 1'b0;
            atkPend_d = 1'b0;
            hitPend_d = 1'b0;

            if (spReq) begin
                displaySp_d = ~displaySp_q;
            end

            case (atkState_q)
                ATK_IDLE: begin
                    if (atkReq) begin
                        atkState_d = ATK_SHOW;
                        atkCnt_d   = ATK_SHOW_LOAD;
                        attackEn_d = 1'b1;
                    end
                end
                ATK_SHOW: begin
                    if (atkCnt_q == '0) begin
                        atkState_d = ATK_COOL;
                        atkCnt_d   = ATK_COOL_LOAD;
                        attackEn_d = 1'b0;
                    end else begin
                        atkCnt_d = atkCnt_q - ATK_W'(1);
                    end
                end
                ATK_COOL: begin
                    if (atkCnt_q == '0) begin
                        atkState_d = ATK_IDLE;
                    end else begin
                        atkCnt_d = atkCnt_q - ATK_W'(1);
                    end
                end
                default: begin
                    atkState_d = ATK_IDLE;
                    atkCnt_d   = '0;
                    attackEn_d = 1'b0;
                end
            endcase

            if (hitReq) begin
                hitCnt_d   = HIT_LOAD;
                blinkCnt_d = '0;
                visible_d  = 1'b0;
                invuln_d   = 1'b1;
            end else if (hitCnt_q > HIT_W'(1)) begin
                hitCnt_d = hitCnt_q - HIT_W'(1);
                if (blinkCnt_q == BLINK_LAST) begin
                    blinkCnt_d = '0;
                    visible_d  = ~visible_q;
                end else begin
                    blinkCnt_d = blinkCnt_q + BLINK_W'(1);
                end
            end else if (hitCnt_q == HIT_W'(1)) begin
                hitCnt_d   = '0;
                blinkCnt_d = '0;
                visible_d  = 1'b1;
                invuln_d   = 1'b0;
            end
        end else begin
            spPend_d  = spPend_q ^ sp_toggle;
            atkPend_d = atkPend_q | attack_req;
            hitPend_d = hitPend_q | player_hit;
        end
    end

    // State register; reset aborts any running sequence immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            atkState_q  <= ATK_IDLE;
            atkCnt_q    <= '0;
            attackEn_q  <= 1'b0;
            hitCnt_q    <= '0;
            blinkCnt_q  <= '0;
            visible_q   <= 1'b1;
            invuln_q    <= 1'b0;
            displaySp_q <= 1'b0;
            spPend_q    <= 1'b0;
            atkPend_q   <= 1'b0;
            hitPend_q   <= 1'b0;
        end else begin
            atkState_q  <= atkState_d;
            atkCnt_q    <= atkCnt_d;
            attackEn_q  <= attackEn_d;
            hitCnt_q    <= hitCnt_d;
            blinkCnt_q  <= blinkCnt_d;
            visible_q   <= visible_d;
            invuln_q    <= invuln_d;
            displaySp_q <= displaySp_d;
            spPend_q    <= spPend_d;
            atkPend_q   <= atkPend_d;
            hitPend_q   <= hitPend_d;
        end
    end

    assign display_sp     = displaySp_q;
    assign attack_en      = attackEn_q;
    assign attack_busy    = (atkState_q != ATK_IDLE);
    assign player_visible = visible_q;
    assign invuln         = invuln_q;

endmodule

// File: tb/tb_layer_fx_ctrl.sv
// tb_layer_fx_ctrl: directed bench for layer_fx_ctrl with default parameters.
// Outputs are compared as a packed vector
// {display_sp, attack_en, attack_busy, player_visible, invuln}.
module tb_layer_fx_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic frame_tick;
    logic sp_toggle;
    logic attack_req;
    logic player_hit;
    logic display_sp;
    logic attack_en;
    logic attack_busy;
    logic player_visible;
    logic invuln;
    logic [4:0] outVec;

    int checkCount = 0;
    int errorCount = 0;

    layer_fx_ctrl #(
        .ATTACK_FRAMES  (8),
        .COOLDOWN_FRAMES(16),
        .HIT_FRAMES     (60),
        .BLINK_PERIOD   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .sp_toggle     (sp_toggle),
        .attack_req    (attack_req),
        .player_hit    (player_hit),
        .display_sp    (display_sp),
        .attack_en     (attack_en),
        .attack_busy   (attack_busy),
        .player_visible(player_visible),
        .invuln        (invuln)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    assign outVec = {display_sp, attack_en, attack_busy, player_visible, invuln};

    // Counts one comparison and reports it when observed and expected differ
    task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Drives one clock cycle of inputs, then returns 1 unit after the edge
    task automatic applyStimulus(input logic rstIn, input logic tick, input logic sp,
                                 input logic atk, input logic hit);
        rst        = rstIn;
        frame_tick = tick;
        sp_toggle  = sp;
        attack_req = atk;
        player_hit = hit;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        frame_tick = 1'b0;
        sp_toggle  = 1'b0;
        attack_req = 1'b0;
        player_hit = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One short frame: event pulses mid-frame, then the frame tick
    task automatic frameStep(input logic sp, input logic atk, input logic hit);
        applyStimulus(1'b0, 1'b0, sp, atk, hit);
        idleCycles(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Two reset cycles with every other input held high
    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    // Directed scenarios in sequence
    initial begin
        logic [4:0] expVec;
        logic       expVis;
        int         phase;

        rst        = 1'b0;
        frame_tick = 1'b0;
        sp_toggle  = 1'b0;
        attack_req = 1'b0;
        player_hit = 1'b0;
        #1;

        $display("[TB] reset");
        doReset();
        checkOutput("reset", outVec, 5'b00010);
        idleCycles(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("tickAfterReset", outVec, 5'b00010);

        $display("[TB] frame alignment");
        for (int c = 0; c < 100; c++) begin
            applyStimulus(1'b0, 1'b0, (c == 5), 1'b0, 1'b0);
            if (c == 6) checkOutput("spHoldAfterPulse", outVec, 5'b00010);
        end
        checkOutput("spBeforeTick", outVec, 5'b00010);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("spAfterTick", outVec, 5'b10010);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("spPairCancel", outVec, 5'b10010);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("spSameCycle", outVec, 5'b00010);

        $display("[TB] attack timing");
        doReset();
        for (int k = 0; k <= 25; k++) begin
            frameStep(1'b0, (k == 0) || (k == 10) || (k == 24) || (k == 25), 1'b0);
            expVec = {1'b0, (k <= 7) || (k == 25), (k <= 23) || (k == 25), 1'b1, 1'b0};
            checkOutput($sformatf("attack T%0d", k), outVec, expVec);
        end

        $display("[TB] hit blink");
        doReset();
        for (int k = 0; k <= 61; k++) begin
            frameStep(1'b0, 1'b0, (k == 0));
            expVis = (k >= 60) ? 1'b1 : (((k / 4) % 2) == 1);
            expVec = {1'b0, 1'b0, 1'b0, expVis, (k <= 59)};
            checkOutput($sformatf("hit T%0d", k), outVec, expVec);
        end

        $display("[TB] retrigger and simultaneous");
        doReset();
        for (int k = 0; k <= 91; k++) begin
            frameStep(1'b0, (k == 0), (k == 0) || (k == 30));
            phase  = (k < 30) ? k : k - 30;
            expVis = (k >= 90) ? 1'b1 : (((phase / 4) % 2) == 1);
            expVec = {1'b0, (k <= 7), (k <= 23), expVis, (k <= 89)};
            checkOutput($sformatf("retrig T%0d", k), outVec, expVec);
        end

        $display("[TB] reset mid-operation");
        doReset();
        frameStep(1'b1, 1'b1, 1'b1);
        frameStep(1'b0, 1'b0, 1'b0);
        frameStep(1'b0, 1'b0, 1'b0);
        checkOutput("midOpRunning", outVec, 5'b11101);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("midOpReset", outVec, 5'b00010);
        frameStep(1'b0, 1'b1, 1'b0);
        checkOutput("postResetAttack", outVec, 5'b01110);
        frameStep(1'b0, 1'b0, 1'b0);
        checkOutput("postResetAttack2", outVec, 5'b01110);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
